// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive pair: FSM state type,
// data width, default bit period and the 3-sample majority helper.
package uart_pkg;

  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned CLKS_PER_BIT_DEF = 10416;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a
// parameterised reset value so an idle-high line does not glitch on reset.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit 3-sample majority vote and one-cycle strobes.
// Optional parity bit (even/odd via PARITY_ODD) when UART_RX_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned TW   = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] T_SMP0 = TW'(HALF - 1);
  localparam logic [TW-1:0] T_SMP1 = TW'(HALF);
  localparam logic [TW-1:0] T_DEC  = TW'(HALF + 1);
  localparam logic [TW-1:0] T_END  = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic          PAR_ODD  = (PARITY_ODD != 0);

  logic                 w_rx_s;
  logic                 r_rx_d;
  uart_state_e          r_state, w_state_nxt;
  logic [TW-1:0]        r_tick, w_tick_nxt;
  logic [2:0]           r_bit_idx, w_bit_idx_nxt;
  logic [1:0]           r_smp, w_smp_nxt;
  logic [DATA_BITS-1:0] r_shreg, w_shreg_nxt;
  logic [DATA_BITS-1:0] r_data, w_data_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_ferr, w_ferr_nxt;
  logic                 r_perr, w_perr_nxt;
  logic                 w_par_bad;
  logic                 w_maj;
  logic                 w_at_dec;
  logic                 w_at_end;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx),
    .o_q (w_rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic r_par_bad, w_par_bad_nxt;
  assign w_par_bad = r_par_bad;
`else
  logic w_unused_par;
  assign w_par_bad    = 1'b0;
  assign w_unused_par = PAR_ODD;
`endif

  // Third sample is taken live at the decision tick, so the vote costs no extra cycle.
  assign w_maj    = maj3(r_smp[0], r_smp[1], w_rx_s);
  assign w_at_dec = (r_tick == T_DEC);
  assign w_at_end = (r_tick == T_END);

  always_comb begin
    w_state_nxt   = r_state;
    w_tick_nxt    = r_tick;
    w_bit_idx_nxt = r_bit_idx;
    w_smp_nxt     = r_smp;
    w_shreg_nxt   = r_shreg;
    w_data_nxt    = r_data;
    w_valid_nxt   = 1'b0;
    w_ferr_nxt    = 1'b0;
    w_perr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_nxt = r_par_bad;
`endif

    if (r_tick == T_SMP0) w_smp_nxt[0] = w_rx_s;
    if (r_tick == T_SMP1) w_smp_nxt[1] = w_rx_s;

    if (r_state != ST_IDLE && r_state != ST_BREAK) begin
      w_tick_nxt = w_at_end ? '0 : r_tick + TW'(1);
    end

    case (r_state)
      ST_IDLE: begin
        if (r_rx_d && !w_rx_s) begin
          w_state_nxt = ST_START;
          w_tick_nxt  = '0;
        end
      end
      ST_START: begin
        if (w_at_dec && w_maj) begin
          w_state_nxt = ST_IDLE;
        end else if (w_at_end) begin
          w_state_nxt   = ST_DATA;
          w_bit_idx_nxt = '0;
        end
      end
      ST_DATA: begin
        if (w_at_dec) w_shreg_nxt[r_bit_idx] = w_maj;
        if (w_at_end) begin
          if (r_bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_at_dec) w_par_bad_nxt = (w_maj != (^r_shreg ^ PAR_ODD));
        if (w_at_end) w_state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
        if (w_at_dec) begin
          if (w_maj) begin
            w_state_nxt = ST_IDLE;
            if (w_par_bad) begin
              w_perr_nxt = 1'b1;
            end else begin
              w_data_nxt  = r_shreg;
              w_valid_nxt = 1'b1;
            end
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (w_rx_s) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_d    <= 1'b1;
      r_state   <= ST_IDLE;
      r_tick    <= '0;
      r_bit_idx <= '0;
      r_smp     <= '0;
      r_shreg   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_rx_d    <= w_rx_s;
      r_state   <= w_state_nxt;
      r_tick    <= w_tick_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_smp     <= w_smp_nxt;
      r_shreg   <= w_shreg_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_ferr    <= w_ferr_nxt;
      r_perr    <= w_perr_nxt;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= w_par_bad_nxt;
`endif
    end
  end

  assign data_out   = r_data;
  assign valid      = r_valid;
  assign frame_err  = r_ferr;
  assign parity_err = r_perr;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clk/bit: directed frames plus random
// frames scored against a frame-level outcome model (honours UART_RX_PARITY_EN).
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam logic PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int LAT = 2 + 9 * CPB + HALF + 2 + (PAR_EN ? CPB : 0);

  localparam int K_VALID = 0;
  localparam int K_FERR  = 1;
  localparam int K_PERR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         t;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       valid, frame_err, parity_err, busy;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];
  logic [7:0] exp_data = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    ev_t o;
    if (valid || frame_err || parity_err) begin
      check("strobe_excl", 32'(valid) + 32'(frame_err) + 32'(parity_err), 32'd1);
      o.kind = valid ? K_VALID : (frame_err ? K_FERR : K_PERR);
      o.data = data_out;
      o.t    = cyc;
      obs_q.push_back(o);
    end
  end

  // Frame outcome from the line-level rules only.
  function automatic int predict(input logic [7:0] b, input logic par_v, input logic stop_v);
    if (!stop_v) return K_FERR;
    if (PAR_EN && (par_v != (^b ^ PODD))) return K_PERR;
    return K_VALID;
  endfunction

  task automatic drive_bit(input logic v, input int goff);
    for (int c = 0; c < CPB; c++) begin
      rx = (c == goff) ? ~v : v;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1, -1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int gbit,
                            input int goff, input logic par_v);
    ev_t e;
    e.kind = predict(b, par_v, stop_v);
    if (e.kind == K_VALID) exp_data = b;
    e.data = exp_data;
    e.t    = cyc + 1 + LAT;
    exp_q.push_back(e);
    drive_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) drive_bit(b[i], (i == gbit) ? goff : -1);
    if (PAR_EN) drive_bit(par_v, -1);
    drive_bit(stop_v, -1);
  endtask

  task automatic drain(input string tag);
    ev_t e, o;
    check({tag, "_nev"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_kind"}, 32'(o.kind), 32'(e.kind));
      check({tag, "_data"}, 32'(o.data), 32'(e.data));
      check({tag, "_lat"},  32'(o.t),    32'(e.t));
    end
    exp_q.delete();
    obs_q.delete();
    check({tag, "_hold"}, 32'(data_out), 32'(exp_data));
  endtask

  function automatic logic good_par(input logic [7:0] b);
    return ^b ^ PODD;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen_busy, done;
    logic [7:0] b;
    logic stop_v, par_v;
    int gbit, gap;

    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  32'(data_out),   32'd0);
    check("rst_valid", 32'(valid),      32'd0);
    check("rst_ferr",  32'(frame_err),  32'd0);
    check("rst_perr",  32'(parity_err), 32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    rst = 1'b0;
    idle_bits(1);

    send_frame(8'h55, 1'b1, -1, -1, good_par(8'h55));
    idle_bits(1);
    drain("f55");
    check("f55_busy", 32'(busy), 32'd0);

    rx = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rx = 1'b1;
    seen_busy = 1'b0;
    done      = 1'b0;
    for (int c = 0; c < HALF + 8 && !done; c++) begin
      @(posedge clk); #1;
      if (busy) seen_busy = 1'b1;
      else if (seen_busy) done = 1'b1;
    end
    check("fs_busy_seen",  32'(seen_busy), 32'd1);
    check("fs_busy_clear", 32'(done),      32'd1);
    idle_bits(1);
    drain("fs");

    send_frame(8'hA5, 1'b0, -1, -1, good_par(8'hA5));
    repeat (40) begin @(posedge clk); #1; end
    check("brk_busy", 32'(busy), 32'd1);
    drain("brk");
    rx = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      @(posedge clk); #1;
      if (!busy) done = 1'b1;
    end
    check("brk_release", 32'(done), 32'd1);
    idle_bits(2);
    drain("brk_idle");

    send_frame(8'h00, 1'b1, 3, HALF, good_par(8'h00));
    idle_bits(1);
    drain("glitch");

    send_frame(8'hA5, 1'b1, -1, -1, good_par(8'hA5));
    send_frame(8'h3C, 1'b1, -1, -1, good_par(8'h3C));
    idle_bits(1);
    drain("b2b");

    b = 8'h5A;
    drive_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) drive_bit(b[i], -1);
    rx = b[4];
    repeat (HALF) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_data",  32'(data_out),   32'd0);
    check("mrst_valid", 32'(valid),      32'd0);
    check("mrst_ferr",  32'(frame_err),  32'd0);
    check("mrst_perr",  32'(parity_err), 32'd0);
    check("mrst_busy",  32'(busy),       32'd0);
    rx = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b0;
    exp_data = 8'h00;
    idle_bits(2);
    drain("mrst");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, -1, -1, 1'b0);
    idle_bits(1);
    drain("par_bad");
    send_frame(8'h07, 1'b1, -1, -1, 1'b1);
    idle_bits(1);
    drain("par_ok");
`endif

    for (int k = 0; k < 10; k++) begin
      b      = 8'($urandom);
      stop_v = ($urandom_range(0, 5) != 0);
      gbit   = int'($urandom_range(0, 11));
      if (gbit > 7) gbit = -1;
      par_v  = good_par(b);
      if ($urandom_range(0, 3) == 0) par_v = ~par_v;
      send_frame(b, stop_v, gbit, int'($urandom_range(4, 12)), par_v);
      gap = int'($urandom_range(0, 2));
      if (!stop_v && gap == 0) gap = 1;
      idle_bits(gap);
    end
    idle_bits(1);
    drain("rand");
    check("rand_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
